// File: rtl/triumph_if_stage_pkg.sv
// Shared definitions for the triumph instruction-fetch stage.
//   INSTR_NOP      : word shown to ID when no instruction is buffered
//   BOOT_ADDR_DEF  : default reset PC
//   if_state_e     : fetch FSM states (IF_IDLE/IF_REQ/IF_WAIT/IF_FLUSH)
//   word_align()   : clears the two byte-offset bits of an address
package triumph_if_stage_pkg;

    localparam logic [31:0] INSTR_NOP     = 32'h0000_0013;
    localparam logic [31:0] BOOT_ADDR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_REQ   = 2'd1,
        IF_WAIT  = 2'd2,
        IF_FLUSH = 2'd3
    } if_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/triumph_if_stage_fetch_fifo.sv
// triumph_fetch_fifo: small synchronous FIFO holding {pc, instr} pairs.
// Ports:
//   clk_i, rst_i      clock / asynchronous active-high reset
//   flush_i           empties the FIFO; wins over push and pop of the same cycle
//   push_i, data_i    write side (accepted when not full, or full with a pop)
//   pop_i             read side (ignored when empty)
//   data_o            head entry, combinational from storage
//   empty_o           no entries
//   count_o           number of stored entries
module triumph_fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             full;
    logic             push_ok;
    logic             pop_ok;
    logic [DEPTH-1:0] we_vec;

    assign empty_o = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count_o = count_reg;
    assign push_ok = push_i & (~full | pop_i);
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = mem_reg[rd_ptr_reg];

    // One write enable per entry; DEPTH is a power of two so the pointers wrap naturally.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign we_vec[gi] = push_ok & ~flush_i & (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we_vec[i]) begin
                mem_reg[i] <= data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/triumph_if_stage.sv
// triumph_if_stage: instruction-fetch stage.
// Holds the PC, issues one outstanding word fetch at a time on a req/gnt/rvalid
// memory port, buffers returned words with their PC in a prefetch FIFO and
// presents the head to ID. A redirect from EX flushes the buffered stream.
// Ports:
//   clk_i, rst_i                  clock / asynchronous active-high reset
//   instr_req_o, instr_addr_o     fetch request and word-aligned address
//   instr_gnt_i                   memory accepted the request
//   instr_rvalid_i, instr_rdata_i read response
//   branch_valid_i, branch_addr_i redirect pulse and target
//   stall_i                       ID cannot accept this cycle
//   instr_valid_o, instr_data_o, pc_id_o   instruction to ID
module triumph_if_stage
    import triumph_if_stage_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = BOOT_ADDR_DEF,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        branch_valid_i,
    input  logic [31:0] branch_addr_i,
    input  logic        stall_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_data_o,
    output logic [31:0] pc_id_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if_state_e     state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic [31:0]   req_pc_reg, req_pc_next;   // PC of the fetch currently in flight

    logic          fifo_push;
    logic          fifo_flush;
    logic          fifo_pop;
    logic [63:0]   fifo_head;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic          inflight;
    logic          issue_ok;
    logic          issue_ok_after_push;

    // A fetch is outstanding exactly while waiting for its response (live or stale).
    assign inflight = (state_reg == IF_WAIT) || (state_reg == IF_FLUSH);
    assign issue_ok = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
    // Occupancy after this cycle's push and pop, with the response retiring the in-flight slot.
    assign issue_ok_after_push = (int'(fifo_count) + 1 - int'(fifo_pop)) < FIFO_DEPTH;

    assign fifo_pop = instr_valid_o & ~stall_i;

    triumph_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .data_i  ({req_pc_reg, instr_rdata_i}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= IF_REQ;
            pc_reg     <= BOOT_ADDR;
            req_pc_reg <= BOOT_ADDR;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            req_pc_reg <= req_pc_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        req_pc_next = req_pc_reg;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;

        unique case (state_reg)
            IF_IDLE: begin
                if (issue_ok) begin
                    state_next = IF_REQ;
                end
            end
            IF_REQ: begin
                if (instr_gnt_i) begin
                    req_pc_next = pc_reg;
                    pc_next     = pc_reg + 32'd4;
                    state_next  = IF_WAIT;
                end
            end
            IF_WAIT: begin
                if (instr_rvalid_i) begin
                    fifo_push  = 1'b1;
                    state_next = issue_ok_after_push ? IF_REQ : IF_IDLE;
                end
            end
            IF_FLUSH: begin
                if (instr_rvalid_i) begin
                    state_next = IF_REQ;
                end
            end
            default: state_next = IF_REQ;
        endcase

        // A redirect overrides everything above: the stream restarts at the target,
        // and a fetch already granted must have its response swallowed in FLUSH.
        if (branch_valid_i) begin
            fifo_flush = 1'b1;
            fifo_push  = 1'b0;
            pc_next    = word_align(branch_addr_i);
            unique case (state_reg)
                IF_IDLE:  state_next = IF_REQ;
                IF_REQ:   state_next = instr_gnt_i ? IF_FLUSH : IF_REQ;
                IF_WAIT:  state_next = instr_rvalid_i ? IF_REQ : IF_FLUSH;
                IF_FLUSH: state_next = instr_rvalid_i ? IF_REQ : IF_FLUSH;
                default:  state_next = IF_REQ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        instr_req_o   = (state_reg == IF_REQ) && !rst_i;
        instr_addr_o  = pc_reg;
        instr_valid_o = ~fifo_empty;
        instr_data_o  = fifo_empty ? INSTR_NOP : fifo_head[31:0];
        pc_id_o       = fifo_empty ? 32'h0 : fifo_head[63:32];
    end

endmodule

// File: tb/tb_triumph_if_stage.sv
module tb_triumph_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = 32'h0;
    logic        branch_valid_i = 1'b0;
    logic [31:0] branch_addr_i = 32'h0;
    logic        stall_i = 1'b0;
    logic        instr_valid_o;
    logic [31:0] instr_data_o;
    logic [31:0] pc_id_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic        auto_rv = 1'b1;

    triumph_if_stage #(
        .BOOT_ADDR  (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .branch_valid_i (branch_valid_i),
        .branch_addr_i  (branch_addr_i),
        .stall_i        (stall_i),
        .instr_valid_o  (instr_valid_o),
        .instr_data_o   (instr_data_o),
        .pc_id_o        (pc_id_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction memory contents as seen by the bench.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1000_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic er, input logic [31:0] ea,
                           input logic ev, input logic [31:0] ep);
        chk({tag, ".req"}, 32'(instr_req_o), 32'(er));
        if (er) chk({tag, ".addr"}, instr_addr_o, ea);
        chk({tag, ".valid"}, 32'(instr_valid_o), 32'(ev));
        if (ev) begin
            chk({tag, ".pc"}, pc_id_o, ep);
            chk({tag, ".data"}, instr_data_o, mem_word(ep));
        end else begin
            chk({tag, ".nop"}, instr_data_o, NOP);
        end
    endtask

    // Advance one clock; a granted request gets its response in the following
    // cycle when auto_rv is set, otherwise it stays pending until give_rv.
    task automatic tick;
        logic        fire;
        logic [31:0] a;
        fire = instr_req_o & instr_gnt_i;
        a    = instr_addr_o;
        @(posedge clk_i);
        #1;
        instr_rvalid_i = 1'b0;
        if (fire) begin
            pend      = 1'b1;
            pend_addr = a;
        end
        if (auto_rv && pend) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_word(pend_addr);
            pend           = 1'b0;
        end
    endtask

    task automatic give_rv;
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = mem_word(pend_addr);
        pend           = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst_i          = 1'b1;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = 32'h0;
        branch_valid_i = 1'b0;
        branch_addr_i  = 32'h0;
        stall_i        = 1'b0;
        pend           = 1'b0;
        auto_rv        = 1'b1;
        #1;
        chk({tag, ".rst_req"}, 32'(instr_req_o), 32'h0);
        chk({tag, ".rst_valid"}, 32'(instr_valid_o), 32'h0);
        chk({tag, ".rst_data"}, instr_data_o, NOP);
        chk({tag, ".rst_pc"}, pc_id_o, 32'h0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        $display("[TB] reset %s released", tag);
    endtask

    typedef struct {
        logic        gnt;
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vt[19];

    function automatic vec_t mk(input logic g, input logic s, input logic er,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.gnt = g; v.stall = s; v.exp_req = er; v.exp_addr = ea;
        v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    initial begin
        // Streaming with gnt tied high, then 10 stalled cycles filling the FIFO,
        // then release. Expected outputs hold before the vector's inputs are clocked.
        vt[0]  = mk(1, 0, 1, 32'h0,  0, 32'h0);
        vt[1]  = mk(1, 0, 0, 32'h0,  0, 32'h0);
        vt[2]  = mk(1, 0, 1, 32'h4,  1, 32'h0);
        vt[3]  = mk(1, 0, 0, 32'h0,  0, 32'h0);
        vt[4]  = mk(1, 1, 1, 32'h8,  1, 32'h4);
        vt[5]  = mk(1, 1, 0, 32'h0,  1, 32'h4);
        for (int i = 6; i <= 13; i++) vt[i] = mk(1, 1, 0, 32'h0, 1, 32'h4);
        vt[14] = mk(1, 0, 0, 32'h0,  1, 32'h4);
        vt[15] = mk(1, 0, 0, 32'h0,  1, 32'h8);
        vt[16] = mk(1, 0, 1, 32'hC,  0, 32'h0);
        vt[17] = mk(1, 0, 0, 32'h0,  0, 32'h0);
        vt[18] = mk(1, 0, 1, 32'h10, 1, 32'hC);

        do_reset("T");
        for (int i = 0; i < 19; i++) begin
            chk_out($sformatf("T%0d", i), vt[i].exp_req, vt[i].exp_addr,
                    vt[i].exp_valid, vt[i].exp_pc);
            $display("[TB] vec %0d req=%0b addr=%h valid=%0b pc=%h data=%h",
                     i, instr_req_o, instr_addr_o, instr_valid_o, pc_id_o, instr_data_o);
            instr_gnt_i = vt[i].gnt;
            stall_i     = vt[i].stall;
            tick();
        end

        // Redirect while waiting: stale response is swallowed, fetch restarts at 0x100.
        do_reset("A");
        auto_rv = 1'b0; instr_gnt_i = 1'b1;
        tick();
        chk_out("A.wait", 0, 32'h0, 0, 32'h0);
        branch_valid_i = 1'b1; branch_addr_i = 32'h100;
        tick();
        branch_valid_i = 1'b0;
        chk_out("A.flush0", 0, 32'h0, 0, 32'h0);
        tick();
        chk_out("A.flush1", 0, 32'h0, 0, 32'h0);
        give_rv();
        tick();
        chk_out("A.req", 1, 32'h100, 0, 32'h0);
        auto_rv = 1'b1;
        tick();
        tick();
        chk_out("A.tgt", 1, 32'h104, 1, 32'h100);
        $display("[TB] seq A redirect in WAIT done");

        // Redirect together with the response: data dropped, target aligned to 0x200.
        do_reset("B");
        auto_rv = 1'b0; instr_gnt_i = 1'b1;
        tick();
        give_rv();
        branch_valid_i = 1'b1; branch_addr_i = 32'h203;
        tick();
        branch_valid_i = 1'b0;
        chk_out("B.req", 1, 32'h200, 0, 32'h0);
        auto_rv = 1'b1;
        tick();
        tick();
        chk_out("B.tgt", 1, 32'h204, 1, 32'h200);
        $display("[TB] seq B redirect with rvalid done");

        // No grant for 5 cycles, then redirect to the top word and check PC wrap.
        do_reset("C");
        instr_gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_out($sformatf("C.hold%0d", i), 1, 32'h0, 0, 32'h0);
            tick();
        end
        branch_valid_i = 1'b1; branch_addr_i = 32'hFFFF_FFFC;
        tick();
        branch_valid_i = 1'b0;
        chk_out("C.top", 1, 32'hFFFF_FFFC, 0, 32'h0);
        instr_gnt_i = 1'b1;
        tick();
        tick();
        chk_out("C.wrap", 1, 32'h0, 1, 32'hFFFF_FFFC);
        $display("[TB] seq C gnt hold and wrap done");

        // Reset asserted in WAIT with a buffered entry and a response on the bus.
        do_reset("D0");
        instr_gnt_i = 1'b1; stall_i = 1'b1;
        tick();
        tick();
        tick();
        chk_out("D.pre", 0, 32'h0, 1, 32'h0);
        do_reset("D");
        instr_gnt_i = 1'b1;
        chk_out("D.boot", 1, 32'h0, 0, 32'h0);
        tick();
        tick();
        chk_out("D.first", 1, 32'h4, 1, 32'h0);
        $display("[TB] seq D reset in WAIT done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
